// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM initiator: command words, FSM states, timing-word widths.
package sdram_pkg;

  localparam int TWORD_W = 8;
  localparam int TLAT_W  = 4;

  localparam logic [TWORD_W-1:0] TW_ONE = TWORD_W'(1);
  localparam logic [TWORD_W-1:0] TW_TWO = TWORD_W'(2);
  localparam logic [TLAT_W-1:0]  TL_ONE = TLAT_W'(1);
  localparam logic [TLAT_W-1:0]  TL_TWO = TLAT_W'(2);

  // {CS,RAS,CAS,WE}
  typedef logic [3:0] cmd_t;
  localparam cmd_t CMD_DESEL = 4'b1111;
  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_PRE   = 4'b0010;
  localparam cmd_t CMD_ACT   = 4'b0011;
  localparam cmd_t CMD_RD    = 4'b0101;
  localparam cmd_t CMD_WR    = 4'b0100;
  localparam cmd_t CMD_BST   = 4'b0110;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_RW,
    ST_LAT,
    ST_BURST,
    ST_REC
  } state_t;

endpackage

// File: rtl/sdram_init_delay.sv
// Loadable down-counter shared by every timed phase; o_zero marks the last cycle of a phase.
module sdram_init_delay
  import sdram_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [TWORD_W-1:0] i_load_val,
  output logic               o_zero
);

  logic [TWORD_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW_ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sdram_initiator.sv
// SDRAM command initiator: PRE -> ACT -> RD/WR with programmed spacing, burst data, recovery.
// Define BURST_STOP_EN to let i_abort terminate a burst with BST; otherwise i_abort has no effect.
module sdram_initiator
  import sdram_pkg::*;
#(
  parameter  int ROW_W  = 12,
  parameter  int COL_W  = 10,
  parameter  int DATA_W = 16,
  localparam int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [ROW_W-1:0]   i_req_row,
  input  logic [COL_W-1:0]   i_req_col,
  input  logic               i_abort,
  input  logic [DATA_W-1:0]  i_wr_data,
  output logic               o_wr_take,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic               o_rd_valid,
  output logic               o_done,
  input  logic [TWORD_W-1:0] i_tpre,
  input  logic [TWORD_W-1:0] i_tcas,
  input  logic [TWORD_W-1:0] i_tburst,
  input  logic [TWORD_W-1:0] i_twait,
  input  logic [TLAT_W-1:0]  i_tlat,
  output logic               o_cs,
  output logic               o_ras,
  output logic               o_cas,
  output logic               o_we,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [DATA_W-1:0]  o_dq_out,
  input  logic [DATA_W-1:0]  i_dq_in
);

  state_t             r_state;
  logic               r_we;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [TWORD_W-1:0] r_tpre, r_tcas, r_tburst, r_twait;
  logic [TLAT_W-1:0]  r_tlat;
  logic               r_done;

  state_t             w_next;
  logic               w_load;
  logic [TWORD_W-1:0] w_load_val;
  logic               w_zero;
  logic               w_accept;
  logic               w_abort;
  state_t             w_post_state;
  cmd_t               w_cmd;

  assign w_accept     = i_req_valid && (r_state == ST_IDLE);
  assign w_post_state = (r_twait != '0) ? ST_REC : ST_IDLE;

`ifdef BURST_STOP_EN
  assign w_abort = i_abort && ((r_state == ST_LAT) || (r_state == ST_BURST));
`else
  assign w_abort = i_abort & 1'b0;
`endif

  sdram_init_delay u_delay (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state != ST_IDLE) && (w_next == ST_IDLE);
    end
  end

  // Request and timing words are frozen at accept; zero burst/latency behave as one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we     <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_tpre   <= '0;
      r_tcas   <= '0;
      r_tburst <= '0;
      r_twait  <= '0;
      r_tlat   <= '0;
    end else if (w_accept) begin
      r_we     <= i_req_we;
      r_row    <= i_req_row;
      r_col    <= i_req_col;
      r_tpre   <= i_tpre;
      r_tcas   <= i_tcas;
      r_tburst <= (i_tburst == '0) ? TW_ONE : i_tburst;
      r_twait  <= i_twait;
      r_tlat   <= (i_tlat == '0) ? TL_ONE : i_tlat;
    end
  end

  // Counter is loaded with (phase length - 1) on entry; a phase ends when it reads zero.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_PRE;
      ST_PRE: begin
        if (r_tpre != '0) begin
          w_next = ST_PRE_WAIT; w_load = 1'b1; w_load_val = r_tpre - TW_ONE;
        end else begin
          w_next = ST_ACT;
        end
      end
      ST_PRE_WAIT: if (w_zero) w_next = ST_ACT;
      ST_ACT: begin
        if (r_tcas != '0) begin
          w_next = ST_ACT_WAIT; w_load = 1'b1; w_load_val = r_tcas - TW_ONE;
        end else begin
          w_next = ST_RW;
        end
      end
      ST_ACT_WAIT: if (w_zero) w_next = ST_RW;
      ST_RW: begin
        w_load = 1'b1;
        if (r_we && (r_tburst > TW_ONE)) begin
          w_next = ST_BURST; w_load_val = r_tburst - TW_TWO;
        end else if (r_we) begin
          w_next = w_post_state; w_load_val = r_twait - TW_ONE;
        end else if (r_tlat > TL_ONE) begin
          w_next = ST_LAT; w_load_val = TWORD_W'(r_tlat - TL_TWO);
        end else begin
          w_next = ST_BURST; w_load_val = r_tburst - TW_ONE;
        end
      end
      ST_LAT: begin
        if (w_abort) begin
          w_next = w_post_state; w_load = 1'b1; w_load_val = r_twait - TW_ONE;
        end else if (w_zero) begin
          w_next = ST_BURST; w_load = 1'b1; w_load_val = r_tburst - TW_ONE;
        end
      end
      ST_BURST: begin
        if (w_abort || w_zero) begin
          w_next = w_post_state; w_load = 1'b1; w_load_val = r_twait - TW_ONE;
        end
      end
      ST_REC: if (w_zero) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd      = CMD_NOP;
    o_addr     = '0;
    o_dq_out   = '0;
    o_wr_take  = 1'b0;
    o_rd_valid = 1'b0;
    o_rd_data  = '0;
    case (r_state)
      ST_IDLE: w_cmd = CMD_DESEL;
      ST_PRE:  w_cmd = CMD_PRE;
      ST_ACT: begin
        w_cmd  = CMD_ACT;
        o_addr = ADDR_W'(r_row);
      end
      ST_RW: begin
        o_addr = ADDR_W'(r_col);
        if (r_we) begin
          w_cmd     = CMD_WR;
          o_wr_take = 1'b1;
          o_dq_out  = i_wr_data;
        end else begin
          w_cmd = CMD_RD;
        end
      end
      ST_LAT: if (w_abort) w_cmd = CMD_BST;
      ST_BURST: begin
        if (w_abort) begin
          w_cmd = CMD_BST;
        end else if (r_we) begin
          o_wr_take = 1'b1;
          o_dq_out  = i_wr_data;
        end else begin
          o_rd_valid = 1'b1;
          o_rd_data  = i_dq_in;
        end
      end
      default: w_cmd = CMD_NOP;
    endcase
  end

  assign {o_cs, o_ras, o_cas, o_we} = w_cmd;
  assign o_req_ready = (r_state == ST_IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_sdram_initiator.sv
// Scoreboard bench for sdram_initiator: expected command/beat/done events are queued from a
// timeline model when a request is issued and compared against events observed each cycle.
module tb_sdram_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        abort = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_take;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic [7:0]  tpre = '0, tcas = '0, tburst = '0, twait = '0;
  logic [3:0]  tlat = '0;
  logic        cs, ras, cas, we_o;
  logic [11:0] addr;
  logic [15:0] dq_out;
  logic [15:0] dq_in = '0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  off;
    logic [15:0] val;
  } ev_t;

  typedef struct packed {
    logic        we;
    logic [11:0] row;
    logic [9:0]  col;
    logic [7:0]  tp, tc, tb, tw;
    logic [3:0]  tl;
  } req_t;

  localparam logic [1:0] K_CMD = 2'd0, K_RD = 2'd1, K_WR = 2'd2, K_DONE = 2'd3;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  t0 = 0;

  sdram_initiator dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_row   (req_row),
    .i_req_col   (req_col),
    .i_abort     (abort),
    .i_wr_data   (wr_data),
    .o_wr_take   (wr_take),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_done      (done),
    .i_tpre      (tpre),
    .i_tcas      (tcas),
    .i_tburst    (tburst),
    .i_twait     (twait),
    .i_tlat      (tlat),
    .o_cs        (cs),
    .o_ras       (ras),
    .o_cas       (cas),
    .o_we        (we_o),
    .o_addr      (addr),
    .o_dq_out    (dq_out),
    .i_dq_in     (dq_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rd_pat(input int o);
    return o[0] ? 16'h5A5A : 16'hA5A5;
  endfunction

  function automatic logic [15:0] wr_pat(input int o);
    return 16'h1000 + o[15:0];
  endfunction

  function automatic ev_t mk(input logic [1:0] k, input int o, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.off  = o[7:0];
    e.val  = v;
    return e;
  endfunction

  // Timeline model: offsets are cycles after the accept edge (offset 0 = PRE).
  task automatic sb_push(input req_t q, input int abort_off);
    int tp, tc, tb, tw, tl, r, b0, nb, last, dn;
    tp = int'(q.tp); tc = int'(q.tc); tw = int'(q.tw);
    tb = (q.tb == 8'd0) ? 1 : int'(q.tb);
    tl = (q.tl == 4'd0) ? 1 : int'(q.tl);
    r  = 2 + tp + tc;
    b0 = q.we ? r : r + tl;
    nb = tb;
    if (abort_off >= 0) nb = (abort_off > b0) ? abort_off - b0 : 0;
    last = (abort_off >= 0) ? abort_off : b0 + nb - 1;
    dn   = last + 1 + tw;
    for (int o = 0; o <= dn; o++) begin
      if (o == 0)         exp_q.push_back(mk(K_CMD, o, {4'b0010, 12'h000}));
      if (o == 1 + tp)    exp_q.push_back(mk(K_CMD, o, {4'b0011, q.row}));
      if (o == r)         exp_q.push_back(mk(K_CMD, o, {(q.we ? 4'b0100 : 4'b0101), 2'b00, q.col}));
      if (o == abort_off) exp_q.push_back(mk(K_CMD, o, {4'b0110, 12'h000}));
      if (o == dn)        exp_q.push_back(mk(K_CMD, o, {4'b1111, 12'h000}));
      if (o >= b0 && o < b0 + nb)
        exp_q.push_back(mk(q.we ? K_WR : K_RD, o, q.we ? wr_pat(o) : rd_pat(o)));
      if (o == dn)        exp_q.push_back(mk(K_DONE, o, 16'h0000));
    end
  endtask

  task automatic drive_fields(input req_t q);
    req_we = q.we; req_row = q.row; req_col = q.col;
    tpre = q.tp; tcas = q.tc; tburst = q.tb; twait = q.tw; tlat = q.tl;
  endtask

  task automatic start_req(input req_t q, input bit hold);
    @(negedge clk);
    drive_fields(q);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  // Records every non-NOP command, beat and Done until Done or the cycle budget runs out.
  task automatic collect(input int max_cyc, input int abort_off);
    int o;
    obs_q.delete();
    for (int k = 0; k < max_cyc; k++) begin
      o = cyc - t0;
      dq_in   = rd_pat(o);
      wr_data = wr_pat(o);
      abort   = (o == abort_off);
      #1;
      if ({cs, ras, cas, we_o} != 4'b0111) obs_q.push_back(mk(K_CMD, o, {cs, ras, cas, we_o, addr}));
      if (rd_valid) obs_q.push_back(mk(K_RD, o, rd_data));
      if (wr_take)  obs_q.push_back(mk(K_WR, o, dq_out));
      if (done) begin
        obs_q.push_back(mk(K_DONE, o, 16'h0000));
        abort = 1'b0;
        return;
      end
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({cs, ras, cas, we_o} !== 4'b1111) begin
      n_err++; $display("FAIL reset_cmd got %b want 1111", {cs, ras, cas, we_o});
    end
    n_cmp++;
    if ({addr, dq_out, rd_data} !== 44'h0) begin
      n_err++; $display("FAIL reset_buses got %h want 0", {addr, dq_out, rd_data});
    end
    n_cmp++;
    if ({req_ready, rd_valid, wr_take, done} !== 4'b1000) begin
      n_err++; $display("FAIL reset_flags got %b want 1000", {req_ready, rd_valid, wr_take, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, cs, ras, cas, we_o, done} !== 6'b111110) begin
      n_err++; $display("FAIL reset_release got %b want 111110", {req_ready, cs, ras, cas, we_o, done});
    end
  endtask

  task automatic test_write();
    req_t q;
    ev_t  got;
    q = '{we:1'b1, row:12'h3A5, col:10'h155, tp:8'd2, tc:8'd3, tb:8'd4, tw:8'd2, tl:4'd1};
    exp_q.delete();
    sb_push(q, -1);
    start_req(q, 1'b0);
    collect(200, -1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL write_events got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL write_ev%0d got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_read();
    req_t q;
    ev_t  got;
    q = '{we:1'b0, row:12'h0F0, col:10'h2AA, tp:8'd1, tc:8'd1, tb:8'd2, tw:8'd1, tl:4'd3};
    exp_q.delete();
    sb_push(q, -1);
    start_req(q, 1'b0);
    collect(200, -1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL read_events got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL read_ev%0d got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  // Zero-length waits skipped; tburst=0 and tlat=0 behave as one.
  task automatic test_min_timing();
    req_t tbl[3];
    ev_t  got;
    tbl[0] = '{we:1'b1, row:12'hFFF, col:10'h3FF, tp:8'd0, tc:8'd0, tb:8'd1, tw:8'd0, tl:4'd0};
    tbl[1] = '{we:1'b0, row:12'h001, col:10'h002, tp:8'd0, tc:8'd0, tb:8'd0, tw:8'd0, tl:4'd0};
    tbl[2] = '{we:1'b1, row:12'h800, col:10'h200, tp:8'd0, tc:8'd1, tb:8'd0, tw:8'd1, tl:4'd5};
    for (int t = 0; t < 3; t++) begin
      exp_q.delete();
      sb_push(tbl[t], -1);
      start_req(tbl[t], 1'b0);
      collect(200, -1);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL min%0d_events got %0d want %0d", t, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        got = (i < obs_q.size()) ? obs_q[i] : '1;
        n_cmp++;
        if (got !== exp_q[i]) begin
          n_err++; $display("FAIL min%0d_ev%0d got %h want %h", t, i, got, exp_q[i]);
        end
      end
    end
  endtask

  // ReqValid held through Done; fields switched mid-op must only affect the second request.
  task automatic test_back_to_back();
    req_t a, b;
    ev_t  got;
    a = '{we:1'b1, row:12'h111, col:10'h0AA, tp:8'd1, tc:8'd1, tb:8'd2, tw:8'd1, tl:4'd1};
    b = '{we:1'b0, row:12'h222, col:10'h155, tp:8'd0, tc:8'd2, tb:8'd3, tw:8'd0, tl:4'd2};
    for (int op = 0; op < 2; op++) begin
      exp_q.delete();
      if (op == 0) begin
        sb_push(a, -1);
        start_req(a, 1'b1);
        drive_fields(b);
      end else begin
        sb_push(b, -1);
        @(negedge clk);
        t0 = cyc;
        req_valid = 1'b0;
      end
      collect(200, -1);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL b2b%0d_events got %0d want %0d", op, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        got = (i < obs_q.size()) ? obs_q[i] : '1;
        n_cmp++;
        if (got !== exp_q[i]) begin
          n_err++; $display("FAIL b2b%0d_ev%0d got %h want %h", op, i, got, exp_q[i]);
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    req_t q;
    q = '{we:1'b1, row:12'h5A5, col:10'h0F0, tp:8'd0, tc:8'd0, tb:8'd8, tw:8'd0, tl:4'd1};
    start_req(q, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wr_take !== 1'b1) begin
      n_err++; $display("FAIL midrst_in_burst got take=%b want 1", wr_take);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({cs, ras, cas, we_o, addr, dq_out, rd_data} !== {4'b1111, 44'h0}) begin
      n_err++; $display("FAIL midrst_outputs got %h want f00000000000", {cs, ras, cas, we_o, addr, dq_out, rd_data});
    end
    n_cmp++;
    if ({req_ready, rd_valid, wr_take, done} !== 4'b1000) begin
      n_err++; $display("FAIL midrst_flags got %b want 1000", {req_ready, rd_valid, wr_take, done});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, cs, wr_take, done} !== 4'b1100) begin
      n_err++; $display("FAIL midrst_release got %b want 1100", {req_ready, cs, wr_take, done});
    end
  endtask

  // Abort during beat 2 of an 8-beat read; only honoured when burst stop is built in.
  task automatic test_abort();
    req_t q;
    ev_t  got;
    int   a_off;
    q = '{we:1'b0, row:12'h0C3, col:10'h3C3, tp:8'd0, tc:8'd0, tb:8'd8, tw:8'd1, tl:4'd2};
    a_off = 2 + 2 + 2;
    exp_q.delete();
`ifdef BURST_STOP_EN
    sb_push(q, a_off);
`else
    sb_push(q, -1);
`endif
    start_req(q, 1'b0);
    collect(200, a_off);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL abort_events got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL abort_ev%0d got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_min_timing();
    test_back_to_back();
    test_reset_mid_burst();
    test_abort();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
